// File: rtl/tap_frame_serializer_pkg.sv
// ---------------------------------------------------------------------------
// tap_frame_serializer_pkg
// Shared types and constants for the tap frame serializer slice.
//   state_e          : frame FSM states (IDLE/HDR/IDX/DATA/CSUM)
//   HEADER_BYTE_DEF  : default first byte of every frame
//   MAX_INDEX_DEF    : highest legal counting-module index
//   IDX_W            : width of the module index field
//   cnt_width()      : byte-counter width for a given tap count
// ---------------------------------------------------------------------------
package tap_frame_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_IDX  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
    localparam int         MAX_INDEX_DEF   = 20;
    localparam int         IDX_W           = 5;

    // A single-byte frame would give $clog2 == 0; keep at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tap_frame_serializer_tap_byte_mux.sv
// ---------------------------------------------------------------------------
// tap_byte_mux
// Combinational selector: returns byte 'sel' of the latched tap buffer
// (byte k = buf_in[8k+7:8k]); out-of-range selects return 8'h00.
//   buf_in   : latched tap buffer, NUM_OF_TAPS bytes
//   sel      : byte index
//   byte_out : selected byte
// ---------------------------------------------------------------------------
module tap_byte_mux #(
    parameter int NUM_OF_TAPS = 15,
    parameter int CNT_W       = 4
) (
    input  logic [NUM_OF_TAPS*8-1:0] buf_in,
    input  logic [CNT_W-1:0]         sel,
    output logic [7:0]               byte_out
);

    always_comb begin
        byte_out = '0;
        for (int unsigned k = 0; k < NUM_OF_TAPS; k++) begin
            if (sel == CNT_W'(k)) begin
                byte_out = buf_in[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/tap_frame_serializer.sv
// ---------------------------------------------------------------------------
// tap_frame_serializer
// Takes one selected tap buffer plus the index of the counting module that
// produced it and streams it to the RS232 byte transmitter as
//   HEADER_BYTE, {3'b000,index}, byte0 .. byte(NUM_OF_TAPS-1) [, checksum]
// using a per-byte ready/strobe handshake (transfer = tx_drl && tx_load).
// Optional feature macro: TAP_FRAME_CHECKSUM_EN appends the XOR of the index
// byte and all data bytes; undefined, the frame ends after the last data byte.
// Ports:
//   clk        : system clock, posedge
//   res        : synchronous active-low reset
//   in_valid   : upstream offers in_index/in_buf
//   in_ready   : frame can be accepted (IDLE only)
//   in_index   : module index, legal 1..MAX_INDEX
//   in_buf     : tap bytes, byte k = in_buf[8k+7:8k]
//   tx_din     : byte presented to the transmitter (registered)
//   tx_drl     : byte-valid strobe (registered)
//   tx_load    : transmitter ready to take a byte
//   busy       : frame in progress
//   frame_done : one-cycle pulse after the final byte transfer
//   drop       : one-cycle pulse after an illegal-index frame is discarded
// ---------------------------------------------------------------------------
module tap_frame_serializer
    import tap_frame_serializer_pkg::*;
#(
    parameter int         NUM_OF_TAPS = 15,
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF,
    parameter int         MAX_INDEX   = MAX_INDEX_DEF
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_index,
    input  logic [NUM_OF_TAPS*8-1:0] in_buf,
    output logic [7:0]               tx_din,
    output logic                     tx_drl,
    input  logic                     tx_load,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     drop
);

    localparam int               CNT_W    = cnt_width(NUM_OF_TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OF_TAPS - 1);
    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(MAX_INDEX);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_OF_TAPS*8-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [7:0]               tx_din_q, tx_din_d;
    logic                     tx_drl_q, tx_drl_d;
    logic                     frame_done_q, frame_done_d;
    logic                     drop_q, drop_d;
`ifdef TAP_FRAME_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    logic                     xfer;
    logic                     idx_legal;
    logic [CNT_W-1:0]         mux_sel;
    logic [7:0]               mux_byte;

    assign xfer      = tx_drl_q && tx_load;
    assign idx_legal = (in_index != '0) && (in_index <= MAX_IDX);

    // Select the byte that will be presented after the current transfer:
    // byte 0 when entering DATA, byte cnt+1 while walking through DATA.
    always_comb begin
        mux_sel = '0;
        if (state_q == ST_DATA && cnt_q != LAST_CNT) begin
            mux_sel = cnt_q + CNT_W'(1);
        end
    end

    tap_byte_mux #(
        .NUM_OF_TAPS (NUM_OF_TAPS),
        .CNT_W       (CNT_W)
    ) u_tap_byte_mux (
        .buf_in   (buf_q),
        .sel      (mux_sel),
        .byte_out (mux_byte)
    );

    // Outputs are registered: the byte for the next state is loaded on the
    // same edge that completes the current transfer, so tx_drl can stay high
    // across back-to-back bytes.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        tx_din_d     = tx_din_q;
        tx_drl_d     = tx_drl_q;
        frame_done_d = 1'b0;
        drop_d       = 1'b0;
`ifdef TAP_FRAME_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    idx_d = in_index;
                    buf_d = in_buf;
                    cnt_d = '0;
`ifdef TAP_FRAME_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (idx_legal) begin
                        state_d  = ST_HDR;
                        tx_drl_d = 1'b1;
                        tx_din_d = HEADER_BYTE;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end

            ST_HDR: begin
                if (xfer) begin
                    state_d  = ST_IDX;
                    tx_din_d = {{(8-IDX_W){1'b0}}, idx_q};
                end
            end

            ST_IDX: begin
                if (xfer) begin
`ifdef TAP_FRAME_CHECKSUM_EN
                    csum_d = csum_q ^ tx_din_q;
`endif
                    state_d  = ST_DATA;
                    cnt_d    = '0;
                    tx_din_d = mux_byte;
                end
            end

            ST_DATA: begin
                if (xfer) begin
`ifdef TAP_FRAME_CHECKSUM_EN
                    csum_d = csum_q ^ tx_din_q;
`endif
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
`ifdef TAP_FRAME_CHECKSUM_EN
                        state_d  = ST_CSUM;
                        tx_din_d = csum_q ^ tx_din_q;
`else
                        state_d      = ST_IDLE;
                        tx_drl_d     = 1'b0;
                        tx_din_d     = '0;
                        frame_done_d = 1'b1;
`endif
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                        tx_din_d = mux_byte;
                    end
                end
            end

`ifdef TAP_FRAME_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    state_d      = ST_IDLE;
                    tx_drl_d     = 1'b0;
                    tx_din_d     = '0;
                    frame_done_d = 1'b1;
                end
            end
`endif

            default: begin
                state_d  = ST_IDLE;
                tx_drl_d = 1'b0;
                tx_din_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            buf_q        <= '0;
            cnt_q        <= '0;
            tx_din_q     <= '0;
            tx_drl_q     <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= 1'b0;
`ifdef TAP_FRAME_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            tx_din_q     <= tx_din_d;
            tx_drl_q     <= tx_drl_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
`ifdef TAP_FRAME_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign tx_din     = tx_din_q;
    assign tx_drl     = tx_drl_q;
    assign frame_done = frame_done_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_tap_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_tap_frame_serializer
// Directed bench for tap_frame_serializer: normal frame, stalled frame,
// illegal-index drops, frame offered while busy, reset mid-frame, and an
// all-0xFF frame at the top legal index. Honours TAP_FRAME_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_tap_frame_serializer;

    localparam int NT = 15;
`ifdef TAP_FRAME_CHECKSUM_EN
    localparam int FLEN = NT + 3;
`else
    localparam int FLEN = NT + 2;
`endif

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_index = '0;
    logic [NT*8-1:0] in_buf = '0;
    logic [7:0]    tx_din;
    logic          tx_drl;
    logic          tx_load = 1'b1;
    logic          busy;
    logic          frame_done;
    logic          drop;

    always #5 clk = ~clk;

    tap_frame_serializer #(
        .NUM_OF_TAPS (NT),
        .HEADER_BYTE (8'hA5),
        .MAX_INDEX   (20)
    ) dut (
        .clk        (clk),
        .res        (res),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_index   (in_index),
        .in_buf     (in_buf),
        .tx_din     (tx_din),
        .tx_drl     (tx_drl),
        .tx_load    (tx_load),
        .busy       (busy),
        .frame_done (frame_done),
        .drop       (drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] got_q[$];
    int         done_at;

    // Offers a frame and returns one tick after the accepting edge, with the
    // upstream inputs already scrambled to prove they were latched.
    task automatic accept(input logic [4:0] idx, input logic [NT*8-1:0] b);
        int w;
        w = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_index = idx;
        in_buf   = b;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_index = 5'h1f;
        in_buf   = {NT{8'h5a}};
    endtask

    // Collects transferred bytes cycle by cycle; e counts edges since the
    // accepting edge. Returns at the negedge where frame_done is seen.
    task automatic collect(input bit toggle, input bit inject, input logic [NT*8-1:0] inj_buf);
        int         e;
        bit         done;
        bit         hold;
        logic [7:0] held;
        e    = 0;
        done = 1'b0;
        hold = 1'b0;
        held = '0;
        got_q.delete();
        done_at = -1;
        while (!done && e < 200) begin
            tx_load = toggle ? ((e % 2) == 0) : 1'b1;
            if (inject && e == 3) begin
                in_valid = 1'b1;
                in_index = 5'd7;
                in_buf   = inj_buf;
            end
            @(negedge clk);
            if (hold && tx_drl) chk("stall_din", 32'(tx_din), 32'(held));
            hold = tx_drl && !tx_load;
            held = tx_din;
            if (inject && e >= 3 && !frame_done) chk("busy_ready", 32'(in_ready), 32'd0);
            if (tx_drl && tx_load) got_q.push_back(tx_din);
            if (frame_done) begin
                done    = 1'b1;
                done_at = e;
                chk("done_idle", 32'({busy, in_ready}), 32'b01);
            end else begin
                @(posedge clk); #1;
                e++;
            end
        end
        tx_load = 1'b1;
        if (!done) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [4:0] idx, input logic [NT*8-1:0] b);
        logic [7:0] exp_q[$];
        logic [7:0] cs;
        exp_q.push_back(8'hA5);
        exp_q.push_back({3'b000, idx});
        cs = {3'b000, idx};
        for (int k = 0; k < NT; k++) begin
            exp_q.push_back(b[8*k +: 8]);
            cs ^= b[8*k +: 8];
        end
`ifdef TAP_FRAME_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    logic [NT*8-1:0] buf_a;
    logic [NT*8-1:0] buf_b;
    logic [NT*8-1:0] buf_f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NT; k++) begin
            buf_a[8*k +: 8] = 8'(k + 1);
            buf_b[8*k +: 8] = 8'(8'h30 + k * 3);
        end
        buf_f = '1;

        // Reset state
        res = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_drl",  32'(tx_drl), 32'd0);
        chk("rst_din",  32'(tx_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        @(posedge clk); #1;
        res = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Basic frame, index 3, bytes 01..0F, tx_load high
        accept(5'd3, buf_a);
        collect(1'b0, 1'b0, '0);
        check_stream("A", 5'd3, buf_a);
        chk("A_done_at", 32'(done_at), 32'(FLEN));
`ifdef TAP_FRAME_CHECKSUM_EN
        if (got_q.size() == FLEN) chk("A_csum", 32'(got_q[FLEN-1]), 32'h03);
`endif

        // Same frame, tx_load toggling every cycle
        accept(5'd3, buf_a);
        collect(1'b1, 1'b0, '0);
        check_stream("T", 5'd3, buf_a);

        // Illegal indices 0 and 21 are consumed and dropped
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_index = 5'd0;
        @(negedge clk);
        chk("drop0_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_index = 5'd21;
        @(negedge clk);
        chk("drop0_pulse", 32'(drop), 32'd1);
        chk("drop0_drl",   32'(tx_drl), 32'd0);
        chk("drop0_busy",  32'(busy), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drop21_pulse", 32'(drop), 32'd1);
        chk("drop21_drl",   32'(tx_drl), 32'd0);
        chk("drop21_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_clear", 32'(drop), 32'd0);

        // Frame offered while busy waits for IDLE, then follows
        accept(5'd3, buf_a);
        collect(1'b0, 1'b1, buf_b);
        check_stream("B1", 5'd3, buf_a);
        chk("B1_done_at", 32'(done_at), 32'(FLEN));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_index = 5'h1f;
        in_buf   = {NT{8'h5a}};
        collect(1'b0, 1'b0, '0);
        check_stream("B2", 5'd7, buf_b);
        chk("B2_done_at", 32'(done_at), 32'(FLEN));

        // Reset during DATA byte k=5
        accept(5'd3, buf_a);
        repeat (7) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_din_k5", 32'(tx_din), 32'h06);
        chk("mid_drl",    32'(tx_drl), 32'd1);
        res = 1'b0;
        @(posedge clk); #1;
        res = 1'b1;
        @(negedge clk);
        chk("mid_rst_drl",   32'(tx_drl), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_din",   32'(tx_din), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_done", 32'({frame_done, tx_drl}), 32'd0);
        end
        accept(5'd3, buf_b);
        collect(1'b0, 1'b0, '0);
        check_stream("R", 5'd3, buf_b);

        // Top legal index, all-0xFF data
        accept(5'd20, buf_f);
        collect(1'b0, 1'b0, '0);
        check_stream("F", 5'd20, buf_f);
        chk("F_done_at", 32'(done_at), 32'(FLEN));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
